// File: rtl/segre_pkg.sv
// Shared definitions for the segre trap controller: datapath width,
// exception cause codes and the trap FSM state encoding.
package segre_pkg;

  localparam int WORD_SIZE = 32;

  // mcause codes for the synchronous exceptions this core can raise
  typedef enum logic [4:0] {
    EXC_FETCH_MISAL = 5'd0,
    EXC_ILLEGAL     = 5'd2,
    EXC_EBREAK      = 5'd3,
    EXC_LD_MISAL    = 5'd4,
    EXC_ST_MISAL    = 5'd6,
    EXC_ECALL       = 5'd11
  } exc_cause_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_WRITE    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_RET      = 3'd4
  } exc_state_e;

endpackage

// File: rtl/segre_exception_unit.sv
// Trap controller: picks the oldest pending exception (or an MRET), flushes
// and stalls the pipeline, writes mepc/mcause through the CSR exception
// port and redirects the pc to mtvec (trap) or mepc (return).
//
// Request interface: every *_i request flag is a level "valid" with no
// ready. A request is taken only when it is present in a cycle where the
// unit is IDLE; in any other state it is dropped, because the instruction
// that raised it is being flushed anyway.
module segre_exception_unit
  import segre_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 if_fetch_misal_i,
  input  logic [WORD_SIZE-1:0] if_pc_i,
  input  logic                 id_illegal_i,
  input  logic                 id_ecall_i,
  input  logic                 id_ebreak_i,
  input  logic                 id_mret_i,
  input  logic [WORD_SIZE-1:0] id_pc_i,
  input  logic                 mem_ld_misal_i,
  input  logic                 mem_st_misal_i,
  input  logic [WORD_SIZE-1:0] mem_pc_i,
  input  logic [WORD_SIZE-1:0] csr_mtvec_i,
  input  logic [WORD_SIZE-1:0] csr_mepc_i,
  output logic                 exc_we_o,
  output logic [WORD_SIZE-1:0] w_data_mtvec_o,
  output logic [WORD_SIZE-1:0] w_data_mepc_o,
  output logic [WORD_SIZE-1:0] w_data_mcause_o,
  output logic                 flush_o,
  output logic                 stall_o,
  output logic                 redirect_o,
  output logic [WORD_SIZE-1:0] redirect_pc_o,
  output logic [CNT_WIDTH-1:0] trap_cnt_o,
  output exc_state_e           state_o
);

  exc_state_e           state;
  logic                 req_valid;
  exc_cause_e           req_cause;
  logic [WORD_SIZE-1:0] req_pc;
  exc_cause_e           cap_cause;
  logic [WORD_SIZE-1:0] cap_pc;
  logic                 we_q;

  // Age-ordered priority encoder: the MEM stage holds the oldest instruction
  always_comb begin
    req_valid = 1'b1;
    req_cause = EXC_FETCH_MISAL;
    req_pc    = '0;
    if (mem_ld_misal_i) begin
      req_cause = EXC_LD_MISAL;
      req_pc    = mem_pc_i;
    end else if (mem_st_misal_i) begin
      req_cause = EXC_ST_MISAL;
      req_pc    = mem_pc_i;
    end else if (id_illegal_i) begin
      req_cause = EXC_ILLEGAL;
      req_pc    = id_pc_i;
    end else if (id_ebreak_i) begin
      req_cause = EXC_EBREAK;
      req_pc    = id_pc_i;
    end else if (id_ecall_i) begin
      req_cause = EXC_ECALL;
      req_pc    = id_pc_i;
    end else if (if_fetch_misal_i) begin
      req_cause = EXC_FETCH_MISAL;
      req_pc    = if_pc_i;
    end else begin
      req_valid = 1'b0;
    end
  end

  // Trap FSM with registered pulse outputs; every non-IDLE state lasts one cycle
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state           <= ST_IDLE;
      cap_cause       <= EXC_FETCH_MISAL;
      cap_pc          <= '0;
      we_q            <= 1'b0;
      w_data_mepc_o   <= '0;
      w_data_mcause_o <= '0;
      flush_o         <= 1'b0;
      stall_o         <= 1'b0;
      redirect_o      <= 1'b0;
      redirect_pc_o   <= '0;
      trap_cnt_o      <= '0;
    end else begin
      we_q            <= 1'b0;
      w_data_mepc_o   <= '0;
      w_data_mcause_o <= '0;
      flush_o         <= 1'b0;
      stall_o         <= 1'b0;
      redirect_o      <= 1'b0;
      redirect_pc_o   <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_cause <= req_cause;
            cap_pc    <= req_pc;
            flush_o   <= 1'b1;
            stall_o   <= 1'b1;
            state     <= ST_FLUSH;
          end else if (id_mret_i) begin
            flush_o       <= 1'b1;
            redirect_o    <= 1'b1;
            redirect_pc_o <= csr_mepc_i;
            state         <= ST_RET;
          end
        end
        ST_FLUSH: begin
          we_q            <= 1'b1;
          stall_o         <= 1'b1;
          w_data_mepc_o   <= cap_pc;
          w_data_mcause_o <= {{(WORD_SIZE-5){1'b0}}, cap_cause};
          state           <= ST_WRITE;
        end
        ST_WRITE: begin
          redirect_o    <= 1'b1;
          redirect_pc_o <= {csr_mtvec_i[WORD_SIZE-1:2], 2'b00};
          if (trap_cnt_o != '1) trap_cnt_o <= trap_cnt_o + CNT_WIDTH'(1);
          state         <= ST_REDIRECT;
        end
        ST_REDIRECT: state <= ST_IDLE;
        ST_RET:      state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // A reset landing on the write cycle cancels the CSR write immediately
  assign exc_we_o       = we_q & rsn_i;
  assign w_data_mtvec_o = exc_we_o ? csr_mtvec_i : '0;
  assign state_o        = state;

endmodule

// File: tb/tb_segre_exception_unit.sv
// Bench for segre_exception_unit: directed cases, random requests and
// counter saturation, all checked against an event-level trap model.
module tb_segre_exception_unit;
  import segre_pkg::*;

  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int EV_FLUSH = 1;
  localparam int EV_WRITE = 2;
  localparam int EV_REDIR = 3;
  localparam int EV_RET   = 4;

  logic        clk = 1'b0;
  logic        rsn_i = 1'b0;
  logic        if_fetch_misal_i, id_illegal_i, id_ecall_i, id_ebreak_i, id_mret_i;
  logic        mem_ld_misal_i, mem_st_misal_i;
  logic [31:0] if_pc_i, id_pc_i, mem_pc_i, csr_mtvec_i, csr_mepc_i;
  logic        exc_we_o, flush_o, stall_o, redirect_o;
  logic [31:0] w_data_mtvec_o, w_data_mepc_o, w_data_mcause_o, redirect_pc_o;
  logic [CW-1:0] trap_cnt_o;
  exc_state_e  state_o;

  segre_exception_unit #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rsn_i(rsn_i),
    .if_fetch_misal_i(if_fetch_misal_i), .if_pc_i(if_pc_i),
    .id_illegal_i(id_illegal_i), .id_ecall_i(id_ecall_i), .id_ebreak_i(id_ebreak_i),
    .id_mret_i(id_mret_i), .id_pc_i(id_pc_i),
    .mem_ld_misal_i(mem_ld_misal_i), .mem_st_misal_i(mem_st_misal_i), .mem_pc_i(mem_pc_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .exc_we_o(exc_we_o), .w_data_mtvec_o(w_data_mtvec_o), .w_data_mepc_o(w_data_mepc_o),
    .w_data_mcause_o(w_data_mcause_o), .flush_o(flush_o), .stall_o(stall_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .trap_cnt_o(trap_cnt_o),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          kind;
    int          at;
    logic [31:0] d0;
    logic [31:0] d1;
  } ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  next_free = 0;
  int  m_cnt = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Unit is free again 4 cycles after accepting a trap, 2 after an MRET.
  task automatic model_issue();
    logic        hit;
    logic [31:0] pc;
    int          cause;
    if (!rsn_i || cyc < next_free) return;
    hit = 1'b1; pc = 0; cause = 0;
    if (mem_ld_misal_i)        begin cause = 4;  pc = mem_pc_i; end
    else if (mem_st_misal_i)   begin cause = 6;  pc = mem_pc_i; end
    else if (id_illegal_i)     begin cause = 2;  pc = id_pc_i;  end
    else if (id_ebreak_i)      begin cause = 3;  pc = id_pc_i;  end
    else if (id_ecall_i)       begin cause = 11; pc = id_pc_i;  end
    else if (if_fetch_misal_i) begin cause = 0;  pc = if_pc_i;  end
    else hit = 1'b0;
    if (hit) begin
      m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      exp_q.push_back('{EV_FLUSH, cyc + 1, 32'h0, 32'h0});
      exp_q.push_back('{EV_WRITE, cyc + 2, pc, cause});
      exp_q.push_back('{EV_REDIR, cyc + 3, csr_mtvec_i & 32'hFFFF_FFFC, m_cnt});
      next_free = cyc + 4;
    end else if (id_mret_i) begin
      exp_q.push_back('{EV_RET, cyc + 1, csr_mepc_i, 32'h0});
      next_free = cyc + 2;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_req();
    if_fetch_misal_i = 0; id_illegal_i = 0; id_ecall_i = 0; id_ebreak_i = 0;
    id_mret_i = 0; mem_ld_misal_i = 0; mem_st_misal_i = 0;
  endtask

  // Inputs are already set; record them in the model and advance one cycle
  task automatic step();
    model_issue();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    clear_req();
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int  ev;
    ev_t e;
    if (mon_en) begin
      ev = 0;
      if (flush_o && redirect_o) ev = EV_RET;
      else if (flush_o)          ev = EV_FLUSH;
      else if (exc_we_o)         ev = EV_WRITE;
      else if (redirect_o)       ev = EV_REDIR;
      check("stall", {31'b0, stall_o}, {31'b0, (ev == EV_FLUSH || ev == EV_WRITE)});
      if (!exc_we_o) begin
        check("mepc_idle", w_data_mepc_o, 0);
        check("mcause_idle", w_data_mcause_o, 0);
        check("mtvec_idle", w_data_mtvec_o, 0);
      end
      if (!redirect_o) check("redirect_pc_idle", redirect_pc_o, 0);
      if (ev != 0) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", ev, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", ev, e.kind);
          check("event_cycle", cyc, e.at);
          case (e.kind)
            EV_WRITE: begin
              check("mepc", w_data_mepc_o, e.d0);
              check("mcause", w_data_mcause_o, e.d1);
              check("mtvec_wdata", w_data_mtvec_o, csr_mtvec_i);
            end
            EV_REDIR: begin
              check("trap_target", redirect_pc_o, e.d0);
              check("trap_cnt", {24'b0, trap_cnt_o}, e.d1);
            end
            EV_RET: begin
              check("ret_target", redirect_pc_o, e.d0);
              check("ret_no_we", {31'b0, exc_we_o}, 0);
            end
            default: ;
          endcase
        end
      end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        checks++; failures++;
        $display("FAIL missing_event: got none at cycle %0d expected kind %0d at cycle %0d",
                 cyc, exp_q[0].kind, exp_q[0].at);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, {31'b0, exc_we_o}, 0);
    check({tag, "_flush"}, {31'b0, flush_o}, 0);
    check({tag, "_stall"}, {31'b0, stall_o}, 0);
    check({tag, "_redirect"}, {31'b0, redirect_o}, 0);
    check({tag, "_redirect_pc"}, redirect_pc_o, 0);
    check({tag, "_mepc"}, w_data_mepc_o, 0);
    check({tag, "_mcause"}, w_data_mcause_o, 0);
    check({tag, "_cnt"}, {24'b0, trap_cnt_o}, 0);
    check({tag, "_state_idle"}, {29'b0, state_o}, {29'b0, ST_IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_req();
    if_pc_i = 0; id_pc_i = 0; mem_pc_i = 0; csr_mtvec_i = 32'h803; csr_mepc_i = 32'h104;
    rsn_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rsn_i = 1;
    next_free = cyc; m_cnt = 0;
    mon_en = 1;
    idle(2);

    // illegal instruction trap to aligned mtvec
    id_illegal_i = 1; id_pc_i = 32'h100; step(); idle(4);
    // load misal beats simultaneous ecall
    mem_ld_misal_i = 1; mem_pc_i = 32'h200; id_ecall_i = 1; id_pc_i = 32'h204; step(); idle(4);
    // mret
    id_mret_i = 1; step(); idle(2);
    // ebreak, then a fetch misal during FLUSH is dropped
    id_ebreak_i = 1; id_pc_i = 32'h300; step();
    clear_req(); if_fetch_misal_i = 1; if_pc_i = 32'h444; step(); idle(4);
    // mret loses to a same-cycle exception
    id_mret_i = 1; mem_st_misal_i = 1; mem_pc_i = 32'h500; step(); idle(4);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if_fetch_misal_i = ($urandom_range(0, 15) == 0);
      id_illegal_i     = ($urandom_range(0, 15) == 0);
      id_ecall_i       = ($urandom_range(0, 15) == 0);
      id_ebreak_i      = ($urandom_range(0, 15) == 0);
      id_mret_i        = ($urandom_range(0, 7) == 0);
      mem_ld_misal_i   = ($urandom_range(0, 15) == 0);
      mem_st_misal_i   = ($urandom_range(0, 15) == 0);
      if_pc_i  = $urandom; id_pc_i = $urandom; mem_pc_i = $urandom;
      if (cyc >= next_free) begin
        csr_mtvec_i = $urandom; csr_mepc_i = $urandom;
      end
      step();
    end
    idle(6);

    // back-to-back traps until the counter saturates
    for (int i = 0; i < CNT_MAX + 10; i++) begin
      id_illegal_i = 1; id_pc_i = $urandom; step(); idle(3);
    end
    idle(4);
    check("cnt_saturated", {24'b0, trap_cnt_o}, CNT_MAX);
    check("queue_drained", exp_q.size(), 0);

    // reset while in WRITE: no CSR write, everything cleared
    mon_en = 0;
    exp_q.delete();
    id_illegal_i = 1; id_pc_i = 32'h600; @(posedge clk); #1;
    clear_req(); @(posedge clk); #1;
    check("reached_write", {29'b0, state_o}, {29'b0, ST_WRITE});
    rsn_i = 0; #1;
    check("reset_write_no_we", {31'b0, exc_we_o}, 0);
    @(posedge clk); #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    check("midreset_no_we", {31'b0, exc_we_o}, 0);
    rsn_i = 1; next_free = cyc; m_cnt = 0;
    mon_en = 1;
    id_ecall_i = 1; id_pc_i = 32'h700; step(); idle(6);
    check("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends on its own
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
